cnn_io_seq: RTL and testbench
=============================

Name: cnn_io_seq

Overview:
- DUT-side endpoint of the CNN lab I/O protocol that the testbench drives.
- Accepts the 75-cycle in_valid burst (Img, Kernel_ch1, Kernel_ch2, Weight, Opt) and converts it into indexed write strobes for the compute core's storage.
- Pulses core_start once the burst is complete.
- Collects the core's 3 fp32 results and replays them on out_valid/out as one contiguous 3-cycle burst that meets the output rules: out is zero when out_valid is low, and out_valid never overlaps in_valid.

Parameters:
- DATA_W, 32, operand/result width (IEEE-754 single)
- IMG_LEN, 75, Img beats per burst
- KER_LEN, 12, Kernel_ch1/Kernel_ch2 beats per burst
- WGT_LEN, 24, Weight beats per burst
- OUT_LEN, 3, results per pattern

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input burst valid
- Img  in  DATA_W  image element
- Kernel_ch1  in  DATA_W  kernel ch1 element; valid on the first KER_LEN beats
- Kernel_ch2  in  DATA_W  kernel ch2 element; valid on the first KER_LEN beats
- Weight  in  DATA_W  FC weight; valid on the first WGT_LEN beats
- Opt  in  1  mode bit; valid on beat 0 only
- wr_idx  out  7  beat index of the current write strobe
- img_we  out  1  write Img element at wr_idx
- ker_we  out  1  write both kernels at wr_idx
- wgt_we  out  1  write Weight at wr_idx
- wr_img  out  DATA_W  registered Img data
- wr_ker1  out  DATA_W  registered Kernel_ch1 data
- wr_ker2  out  DATA_W  registered Kernel_ch2 data
- wr_wgt  out  DATA_W  registered Weight data
- opt_q  out  1  latched Opt, held until the next burst
- core_start  out  1  one-cycle start pulse to the core
- res_valid  in  1  core result strobe
- res_data  in  DATA_W  core result
- out_valid  out  1  output valid
- out  out  DATA_W  output result
- protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n=0): every output is 0, all counters are 0, state is IDLE. Reset mid-burst or mid-drain aborts immediately; after reset release the block waits for a fresh burst.
- FSM: IDLE -> LOAD -> WAIT -> DRAIN -> IDLE.
- IDLE:
  - in_valid=1 latches Opt into opt_q, clears protocol_err, registers beat 0 and goes to LOAD with beat count 1.
  - res_valid is ignored.
- LOAD: each in_valid beat k (0..74) appears one cycle later as:
  - wr_idx=k
  - img_we=1
  - ker_we=(k<KER_LEN)
  - wgt_we=(k<WGT_LEN)
  - registered data on wr_*
  - Strobes are 0 on all other cycles; wr_* data is don't-care when its strobe is 0. X inputs on unused lanes are never written.
- End of burst:
  - The cycle after the wr_idx=74 strobe, core_start=1 for exactly one cycle and the state goes to WAIT.
  - If in_valid falls before IMG_LEN beats: protocol_err=1, no core_start, return to IDLE.
  - If in_valid stays high past beat 74: extra beats are ignored and protocol_err=1.
- WAIT:
  - Each res_valid=1 stores res_data into slot rcnt (0..2) and increments rcnt.
  - When the third result is stored, go to DRAIN on the next edge.
  - Results may arrive back-to-back or with gaps.
- DRAIN:
  - out_valid=1 for exactly OUT_LEN consecutive cycles, starting the cycle after the third result is captured.
  - out = slot 0, 1, 2 in arrival order, then out_valid=0, out=0, state IDLE.
- Output idle rule: out=0 whenever out_valid=0 (out is registered and explicitly zeroed).
- Non-IDLE events:
  - in_valid in WAIT or DRAIN is ignored and sets protocol_err; out_valid is unaffected.
  - res_valid outside WAIT is ignored; a 4th result in the same pattern is dropped.
- Counters: beat counter is 7-bit and saturates at IMG_LEN; rcnt is 2-bit and saturates at OUT_LEN.

Optional Feature:
- Macro: CNN_IO_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog counts WAIT cycles.
  - If 200 cycles pass without the third result, the FSM forces DRAIN with the missing slots = 0 and sets protocol_err.
  - The counter resets on entry to WAIT.
- When undefined: WAIT waits indefinitely and the watchdog logic is absent.

Decomposition:
- Package cnn_io_pkg holds:
  - state enum {IDLE, LOAD, WAIT, DRAIN}
  - constants IMG_LEN, KER_LEN, WGT_LEN, OUT_LEN
  - TIMEOUT_CYC=200
  - fp32 typedef
- One sub-module, cnn_io_outbuf: the 3-entry result buffer plus drain sequencer (inputs: capture, drain go; outputs: out_valid/out, full).

Test Plan:
- Reset during LOAD at beat 30 -> all outputs 0 immediately; a new 75-beat burst then gives wr_idx 0..74 and one core_start.
- Full burst, Opt=1, Kernel_ch1 beat 3=0x3F800000 -> opt_q=1; ker_we at wr_idx 3 with wr_ker1=0x3F800000; ker_we=0 for idx>=12; wgt_we=0 for idx>=24; core_start exactly 1 cycle, one cycle after wr_idx=74.
- Results 0x40000000, 0xBF800000, 0x00000000 with gaps of 0, 5 and 2 cycles -> out_valid high 3 consecutive cycles, out in that order; out=0 before and after.
- in_valid drops after 40 beats -> protocol_err=1, no core_start, next full burst clears the flag and runs normally.
- in_valid asserted during DRAIN -> out burst unaffected, protocol_err=1.
- CNN_IO_TIMEOUT_EN, only 1 result delivered -> at WAIT cycle 200, out = {r0, 0, 0} over 3 cycles and protocol_err=1.

Source files
------------

// File: rtl/cnn_io_pkg.sv
// Shared types and constants for the CNN lab I/O sequencer: FSM states,
// burst lengths and the fp32 operand type.
package cnn_io_pkg;

    localparam int DATA_W      = 32;
    localparam int IMG_LEN     = 75;
    localparam int KER_LEN     = 12;
    localparam int WGT_LEN     = 24;
    localparam int OUT_LEN     = 3;
    localparam int TIMEOUT_CYC = 200;

    typedef logic [DATA_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DRAIN
    } state_e;

endpackage

// File: rtl/cnn_io_seq_if.sv
// Bundle of the lab-protocol burst, core write/result signals and output burst.
// The bench drives through master; the sequencer sits on slave.
interface cnn_io_seq_if;
    import cnn_io_pkg::*;

    logic       in_valid;
    fp32_t      Img;
    fp32_t      Kernel_ch1;
    fp32_t      Kernel_ch2;
    fp32_t      Weight;
    logic       Opt;
    logic [6:0] wr_idx;
    logic       img_we;
    logic       ker_we;
    logic       wgt_we;
    fp32_t      wr_img;
    fp32_t      wr_ker1;
    fp32_t      wr_ker2;
    fp32_t      wr_wgt;
    logic       opt_q;
    logic       core_start;
    logic       res_valid;
    fp32_t      res_data;
    logic       out_valid;
    fp32_t      out;
    logic       protocol_err;

    modport master (
        output in_valid, Img, Kernel_ch1, Kernel_ch2, Weight, Opt, res_valid, res_data,
        input  wr_idx, img_we, ker_we, wgt_we, wr_img, wr_ker1, wr_ker2, wr_wgt,
               opt_q, core_start, out_valid, out, protocol_err
    );

    modport slave (
        input  in_valid, Img, Kernel_ch1, Kernel_ch2, Weight, Opt, res_valid, res_data,
        output wr_idx, img_we, ker_we, wgt_we, wr_img, wr_ker1, wr_ker2, wr_wgt,
               opt_q, core_start, out_valid, out, protocol_err
    );

endinterface

// File: rtl/cnn_io_outbuf.sv
// Three-slot result buffer and drain sequencer: captures core results in
// arrival order and replays them as one contiguous out_valid burst.
module cnn_io_outbuf
    import cnn_io_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_i,
    input  logic  cap_i,
    input  fp32_t cap_data_i,
    input  logic  go_i,
    output logic  full_o,
    output logic  done_o,
    output logic  out_valid_o,
    output fp32_t out_o
);

    fp32_t      slot_q [OUT_LEN];
    logic [1:0] rcnt_q;
    logic [1:0] rd_q;
    logic       busy_q;

    assign full_o = (rcnt_q == 2'(OUT_LEN));
    assign done_o = busy_q && (rd_q == 2'(OUT_LEN));

    // Slots are cleared per pattern so a watchdog-forced drain replays zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_LEN; i++) slot_q[i] <= '0;
            rcnt_q      <= '0;
            rd_q        <= '0;
            busy_q      <= 1'b0;
            out_valid_o <= 1'b0;
            out_o       <= '0;
        end else begin
            if (clr_i) begin
                for (int i = 0; i < OUT_LEN; i++) slot_q[i] <= '0;
                rcnt_q <= '0;
            end else if (cap_i && !full_o) begin
                slot_q[rcnt_q] <= cap_data_i;
                rcnt_q         <= rcnt_q + 2'd1;
            end

            if (go_i) begin
                busy_q      <= 1'b1;
                out_valid_o <= 1'b1;
                out_o       <= slot_q[0];
                rd_q        <= 2'd1;
            end else if (busy_q) begin
                if (rd_q == 2'(OUT_LEN)) begin
                    busy_q      <= 1'b0;
                    out_valid_o <= 1'b0;
                    out_o       <= '0;
                    rd_q        <= '0;
                end else begin
                    out_o <= slot_q[rd_q];
                    rd_q  <= rd_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cnn_io_seq.sv
// DUT-side endpoint of the CNN lab I/O protocol: burst -> indexed write strobes,
// core start pulse, result drain. Optional WAIT watchdog under CNN_IO_TIMEOUT_EN.
module cnn_io_seq
    import cnn_io_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    cnn_io_seq_if.slave io
);

    state_e     state_q, state_d;
    logic [6:0] beat_q, beat_d;
    logic [6:0] wr_idx_q, wr_idx_d;
    logic       img_we_q, img_we_d, ker_we_q, ker_we_d, wgt_we_q, wgt_we_d;
    fp32_t      wr_img_q, wr_img_d, wr_ker1_q, wr_ker1_d;
    fp32_t      wr_ker2_q, wr_ker2_d, wr_wgt_q, wr_wgt_d;
    logic       opt_q, opt_d, err_q, err_d, start_q, start_d;
    logic       take, clr, cap, go, full, done, timeout;

`ifdef CNN_IO_TIMEOUT_EN
    logic [7:0] wdog_q;

    // Counts cycles spent in WAIT; held at zero everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wdog_q <= '0;
        else if (state_q == WAIT)  wdog_q <= wdog_q + 8'd1;
        else                       wdog_q <= '0;
    end

    assign timeout = (state_q == WAIT) && !full && (wdog_q == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign cap = (state_q == WAIT) && io.res_valid;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wr_idx_d  = wr_idx_q;
        img_we_d  = 1'b0;
        ker_we_d  = 1'b0;
        wgt_we_d  = 1'b0;
        wr_img_d  = wr_img_q;
        wr_ker1_d = wr_ker1_q;
        wr_ker2_d = wr_ker2_q;
        wr_wgt_d  = wr_wgt_q;
        opt_d     = opt_q;
        err_d     = err_q;
        start_d   = 1'b0;
        take      = 1'b0;
        clr       = 1'b0;
        go        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    opt_d   = io.Opt;
                    err_d   = 1'b0;
                    clr     = 1'b1;
                    take    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat_q == 7'(IMG_LEN)) begin
                    start_d = 1'b1;
                    beat_d  = '0;
                    state_d = WAIT;
                    if (io.in_valid) err_d = 1'b1;
                end else if (io.in_valid) begin
                    take = 1'b1;
                end else begin
                    err_d   = 1'b1;
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (io.in_valid) err_d = 1'b1;
                if (full || timeout) begin
                    go      = 1'b1;
                    state_d = DRAIN;
                    if (timeout) err_d = 1'b1;
                end
            end
            DRAIN: begin
                if (io.in_valid) err_d = 1'b1;
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Unused lanes are left untouched so X on them never reaches wr_*.
        if (take) begin
            wr_idx_d = beat_q;
            img_we_d = 1'b1;
            ker_we_d = (beat_q < 7'(KER_LEN));
            wgt_we_d = (beat_q < 7'(WGT_LEN));
            wr_img_d = io.Img;
            if (ker_we_d) begin
                wr_ker1_d = io.Kernel_ch1;
                wr_ker2_d = io.Kernel_ch2;
            end
            if (wgt_we_d) wr_wgt_d = io.Weight;
            beat_d = beat_q + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wr_idx_q  <= '0;
            img_we_q  <= 1'b0;
            ker_we_q  <= 1'b0;
            wgt_we_q  <= 1'b0;
            wr_img_q  <= '0;
            wr_ker1_q <= '0;
            wr_ker2_q <= '0;
            wr_wgt_q  <= '0;
            opt_q     <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wr_idx_q  <= wr_idx_d;
            img_we_q  <= img_we_d;
            ker_we_q  <= ker_we_d;
            wgt_we_q  <= wgt_we_d;
            wr_img_q  <= wr_img_d;
            wr_ker1_q <= wr_ker1_d;
            wr_ker2_q <= wr_ker2_d;
            wr_wgt_q  <= wr_wgt_d;
            opt_q     <= opt_d;
            err_q     <= err_d;
            start_q   <= start_d;
        end
    end

    cnn_io_outbuf u_outbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .cap_i       (cap),
        .cap_data_i  (io.res_data),
        .go_i        (go),
        .full_o      (full),
        .done_o      (done),
        .out_valid_o (io.out_valid),
        .out_o       (io.out)
    );

    assign io.wr_idx       = wr_idx_q;
    assign io.img_we       = img_we_q;
    assign io.ker_we       = ker_we_q;
    assign io.wgt_we       = wgt_we_q;
    assign io.wr_img       = wr_img_q;
    assign io.wr_ker1      = wr_ker1_q;
    assign io.wr_ker2      = wr_ker2_q;
    assign io.wr_wgt       = wr_wgt_q;
    assign io.opt_q        = opt_q;
    assign io.core_start   = start_q;
    assign io.protocol_err = err_q;

endmodule

// File: tb/tb_cnn_io_seq.sv
// Directed self-checking bench for cnn_io_seq: reset, burst strobes, result
// drain ordering, short/overlong bursts and the optional WAIT watchdog.
module tb_cnn_io_seq;
    import cnn_io_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    cnn_io_seq_if bus ();

    cnn_io_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid   = 1'b0;
        bus.Img        = '0;
        bus.Kernel_ch1 = '0;
        bus.Kernel_ch2 = '0;
        bus.Weight     = '0;
        bus.Opt        = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_data   = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_idx"},   32'(bus.wr_idx), 32'd0);
        chk({tag, "_imgwe"}, 32'(bus.img_we), 32'd0);
        chk({tag, "_kerwe"}, 32'(bus.ker_we), 32'd0);
        chk({tag, "_wgtwe"}, 32'(bus.wgt_we), 32'd0);
        chk({tag, "_wrimg"}, bus.wr_img, 32'd0);
        chk({tag, "_start"}, 32'(bus.core_start), 32'd0);
        chk({tag, "_oval"},  32'(bus.out_valid), 32'd0);
        chk({tag, "_out"},   bus.out, 32'd0);
        chk({tag, "_err"},   32'(bus.protocol_err), 32'd0);
        chk({tag, "_opt"},   32'(bus.opt_q), 32'd0);
    endtask

    // Drives n beats and checks each registered strobe one cycle later.
    task automatic send_burst(input int n, input logic opt);
        for (int k = 0; k < n; k++) begin
            bus.in_valid   = 1'b1;
            bus.Opt        = (k == 0) ? opt : 1'bx;
            bus.Img        = 32'h1000_0000 + 32'(k);
            bus.Kernel_ch1 = (k == 3) ? 32'h3F80_0000 : ((k < KER_LEN) ? 32'h2000_0000 + 32'(k) : 'x);
            bus.Kernel_ch2 = (k < KER_LEN) ? 32'h3000_0000 + 32'(k) : 'x;
            bus.Weight     = (k < WGT_LEN) ? 32'h4000_0000 + 32'(k) : 'x;
            step();
            chk("wr_idx", 32'(bus.wr_idx), 32'(k));
            chk("img_we", 32'(bus.img_we), 32'd1);
            chk("ker_we", 32'(bus.ker_we), 32'(k < KER_LEN));
            chk("wgt_we", 32'(bus.wgt_we), 32'(k < WGT_LEN));
            chk("wr_img", bus.wr_img, 32'h1000_0000 + 32'(k));
            if (k == 3) chk("wr_ker1_b3", bus.wr_ker1, 32'h3F80_0000);
            if (k == 5) chk("wr_ker2_b5", bus.wr_ker2, 32'h3000_0005);
            if (k == 23) chk("wr_wgt_b23", bus.wr_wgt, 32'h4000_0017);
            chk("no_start_load", 32'(bus.core_start), 32'd0);
        end
        drive_idle();
    endtask

    task automatic end_burst(input logic opt);
        step();
        chk("core_start", 32'(bus.core_start), 32'd1);
        chk("strobe_off", 32'(bus.img_we), 32'd0);
        chk("opt_q", 32'(bus.opt_q), 32'(opt));
        step();
        chk("start_1cyc", 32'(bus.core_start), 32'd0);
    endtask

    task automatic give_res(input logic [31:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            step();
            chk("gap_out_zero", bus.out, 32'd0);
            chk("gap_oval_zero", 32'(bus.out_valid), 32'd0);
        end
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        step();
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
    endtask

    task automatic expect_drain(input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] r2, input int lat, input int limit,
                                input bit inject);
        int w = 0;
        while (bus.out_valid !== 1'b1 && w < limit) begin
            chk("pre_out_zero", bus.out, 32'd0);
            step();
            w++;
        end
        chk("drain_start", 32'(bus.out_valid), 32'd1);
        if (lat >= 0) chk("drain_lat", 32'(w), 32'(lat));
        chk("out0", bus.out, r0);
        if (inject) bus.in_valid = 1'b1;
        step();
        chk("oval1", 32'(bus.out_valid), 32'd1);
        chk("out1", bus.out, r1);
        step();
        chk("oval2", 32'(bus.out_valid), 32'd1);
        chk("out2", bus.out, r2);
        bus.in_valid = 1'b0;
        step();
        chk("oval_end", 32'(bus.out_valid), 32'd0);
        chk("out_end", bus.out, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        step();

        // Reset in the middle of LOAD, then a clean burst
        send_burst(30, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_rst", 32'(bus.img_we), 32'd0);

        send_burst(IMG_LEN, 1'b1);
        end_burst(1'b1);
        give_res(32'h4000_0000, 0);
        give_res(32'hBF80_0000, 5);
        give_res(32'h0000_0000, 2);
        expect_drain(32'h4000_0000, 32'hBF80_0000, 32'h0000_0000, 1, 8, 1'b0);
        chk("err_clean", 32'(bus.protocol_err), 32'd0);

        // Short burst: 40 beats
        send_burst(40, 1'b1);
        step();
        chk("short_err", 32'(bus.protocol_err), 32'd1);
        chk("short_nostart", 32'(bus.core_start), 32'd0);
        step();
        chk("short_nostart2", 32'(bus.core_start), 32'd0);
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hDEAD_BEEF;
        step();
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        chk("idle_res_no_out", 32'(bus.out_valid), 32'd0);

        // Recovery burst with Opt=0; four back-to-back results, fourth dropped
        send_burst(IMG_LEN, 1'b0);
        chk("err_cleared", 32'(bus.protocol_err), 32'd0);
        end_burst(1'b0);
        give_res(32'h1111_1111, 0);
        give_res(32'h2222_2222, 0);
        give_res(32'h3333_3333, 0);
        give_res(32'h4444_4444, 0);
        expect_drain(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, -1, 8, 1'b0);
        chk("no_err_4th", 32'(bus.protocol_err), 32'd0);

        // in_valid during DRAIN
        send_burst(IMG_LEN, 1'b1);
        end_burst(1'b1);
        give_res(32'hAAAA_0001, 1);
        give_res(32'hAAAA_0002, 0);
        give_res(32'hAAAA_0003, 0);
        expect_drain(32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 1, 8, 1'b1);
        chk("drain_inval_err", 32'(bus.protocol_err), 32'd1);

`ifdef CNN_IO_TIMEOUT_EN
        // Only one result: watchdog forces drain with zero fill
        send_burst(IMG_LEN, 1'b0);
        end_burst(1'b0);
        give_res(32'h4040_0000, 0);
        expect_drain(32'h4040_0000, 32'h0, 32'h0, -1, 300, 1'b0);
        chk("timeout_err", 32'(bus.protocol_err), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
